bias_loader: RTL
================

Name: bias_loader

Overview:
- Writer side of the bias buffer's loader port.
- Accepts a valid/ready stream of ACC_WIDTH-bit bias words from the DMA/host path and packs K_CHANNELS consecutive words into one buffer entry.
- Issues one registered write per entry on the wr_en/wr_addr/wr_data loader interface, starting at a programmed base address.
- Sits between the weight/bias DMA stream and bias_buffer; the controller kicks it off per layer and waits for done.

Parameters:
- DEPTH, 64, number of bias_buffer entries; must match the connected buffer.
- ADDR_W, $clog2(DEPTH), entry address width.
- K_CHANNELS and ACC_WIDTH are not parameters; they come from definitions.sv, identical to the buffer.

Ports:
- clk_i  in  1  clock.
- rst_async_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  single-cycle start pulse; honoured only in IDLE.
- base_addr_i  in  ADDR_W  first entry address; sampled on accepted start.
- num_entries_i  in  ADDR_W+1  entries to load; sampled on accepted start; values above DEPTH saturate to DEPTH.
- busy_o  out  1  high while not IDLE.
- done_o  out  1  one-cycle pulse on completion.
- err_o  out  1  sticky framing error; cleared on accepted start.
- s_valid_i  in  1  stream word valid.
- s_ready_o  out  1  stream ready.
- s_data_i  in  ACC_WIDTH  one bias value.
- s_last_i  in  1  marks the final word of the transfer.
- loader_wr_en_o  out  1  buffer write enable.
- loader_wr_addr_o  out  ADDR_W  buffer write address.
- loader_wr_data_o  out  K_CHANNELS x ACC_WIDTH  packed entry; lane 0 is least significant.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; lane and entry counters 0; pack register 0.
- Reset mid-transfer: same as above. Any partial entry is discarded and no write is issued.
- FSM states:
  - IDLE: start_i with num_entries_i==0 goes to DONE with no writes. start_i with num_entries_i>0 goes to LOAD and clears err_o, lane_cnt and entry_cnt.
  - LOAD: leave when the final entry's write has been issued.
  - DONE: done_o=1 for exactly one cycle, then IDLE.
- start_i outside IDLE is ignored. It has no effect on counters, err_o or the latched parameters.
- s_ready_o is 1 in every LOAD cycle and 0 in IDLE and DONE. The buffer never back-pressures, so throughput is one word per cycle.
- A handshake is s_valid_i && s_ready_o. The stalled word is held by the source and not consumed.
- On a handshake with lane_cnt<K_CHANNELS-1: pack[lane_cnt] <= s_data_i and lane_cnt++.
- On a handshake with lane_cnt==K_CHANNELS-1, the next cycle has:
  - loader_wr_en_o=1;
  - loader_wr_data_o = {s_data_i, pack[K_CHANNELS-2:0]};
  - loader_wr_addr_o = (base + entry_cnt) mod DEPTH, wrapping past DEPTH-1 to 0.
  - In the same handshake cycle, lane_cnt resets to 0 and entry_cnt increments.
- Write latency: wr_en asserts exactly one cycle after the entry's K-th word handshake.
- wr_en is a single-cycle pulse per entry. wr_addr and wr_data are held until the next write.
- Back-to-back entries give a write every K_CHANNELS cycles with no bubble.
- When the last entry's K-th word handshakes, the FSM goes to DONE. The final write and done_o occur in the same cycle.
- Framing rules:
  - s_last_i on any accepted word other than the final word sets err_o. Counting continues, so exactly num_entries writes still occur.
  - A missing s_last_i on the final word also sets err_o.
  - err_o stays set until the next accepted start.
- busy_o = (state != IDLE).
- No data arithmetic is performed. Words are placed bit-exact into lanes.

Test Plan:
- Basic load, base=0, num=2, words 0x1..0x(2K) with s_last on the last word.
  - Required: wr_en at cycles K+1 and 2K+1 after start; addr 0 then 1.
  - Entry 0 lane i = i+1; entry 1 lane i = K+i+1.
  - done_o coincides with the second write; err_o=0.
- Wrap-around, base=DEPTH-1, num=2.
  - Required: writes to DEPTH-1 then 0.
  - Read back through bias_buffer returns the packed values.
- Random s_valid gaps, plus mid-transfer start pulses, num=3.
  - Required: exactly 3 writes with correct packing.
  - Extra start pulses are ignored; busy_o stays high throughout.
- Framing errors:
  - s_last on word 1 of 2K: err_o=1, still 2 writes.
  - No s_last on the final word: err_o=1.
  - A clean next start clears err_o.
- num_entries=0 start.
  - Required: no wr_en; busy_o high for one cycle; done_o pulses on the next cycle.
- num_entries=DEPTH+5.
  - Required: saturates to DEPTH, giving exactly DEPTH writes.
- Reset mid-entry: assert rst_async_n_i after K-1 words.
  - Required: all outputs 0 immediately; no write issued.
  - A following start with num=1 loads correctly from lane 0.

Source files
------------

// File: rtl/bias_loader.sv
// Packs K_CHANNELS stream words per bias_buffer entry; one registered write per entry, one cycle after the entry's last word.
// Ready is high in every LOAD cycle and nowhere else; the buffer side never stalls, so throughput is one word per cycle.
package definitions_pkg;
  localparam int K_CHANNELS = 4;
  localparam int ACC_WIDTH  = 32;
endpackage

module bias_loader
  import definitions_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                            clk_i,
  input  logic                            rst_async_n_i,
  input  logic                            start_i,
  input  logic [ADDR_W-1:0]               base_addr_i,
  input  logic [ADDR_W:0]                 num_entries_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            err_o,
  input  logic                            s_valid_i,
  output logic                            s_ready_o,
  input  logic [ACC_WIDTH-1:0]            s_data_i,
  input  logic                            s_last_i,
  output logic                            loader_wr_en_o,
  output logic [ADDR_W-1:0]               loader_wr_addr_o,
  output logic [K_CHANNELS*ACC_WIDTH-1:0] loader_wr_data_o
);

  localparam int LANE_W = (K_CHANNELS > 1) ? $clog2(K_CHANNELS) : 1;
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(K_CHANNELS - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                               state_q, state_d;
  logic [LANE_W-1:0]                    lane_cnt_q, lane_cnt_d;
  logic [CNT_W-1:0]                     entry_cnt_q, entry_cnt_d;
  logic [CNT_W-1:0]                     num_q, num_d;
  logic [ADDR_W-1:0]                    cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0]                    wr_addr_q, wr_addr_d;
  logic [K_CHANNELS-1:0][ACC_WIDTH-1:0] pack_q, pack_d;
  logic [K_CHANNELS-1:0][ACC_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                                 wr_en_q, wr_en_d;
  logic                                 err_q, err_d;

  logic              hs;
  logic              lane_full;
  logic              final_word;
  logic [CNT_W-1:0]  num_sat;
  logic [ADDR_W-1:0] base_mod;

  always_comb begin
    num_sat    = (num_entries_i > DEPTH_C) ? DEPTH_C : num_entries_i;
    // Running address is kept in range so wrap needs only a compare with DEPTH-1.
    base_mod   = (CNT_W'(base_addr_i) >= DEPTH_C) ?
                 ADDR_W'(CNT_W'(base_addr_i) - DEPTH_C) : base_addr_i;
    hs         = s_valid_i && (state_q == LOAD);
    lane_full  = (lane_cnt_q == LAST_LANE);
    final_word = lane_full && ((entry_cnt_q + CNT_W'(1)) == num_q);
  end

  always_comb begin
    state_d     = state_q;
    lane_cnt_d  = lane_cnt_q;
    entry_cnt_d = entry_cnt_q;
    num_d       = num_q;
    cur_addr_d  = cur_addr_q;
    wr_addr_d   = wr_addr_q;
    pack_d      = pack_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          err_d       = 1'b0;
          lane_cnt_d  = '0;
          entry_cnt_d = '0;
          num_d       = num_sat;
          cur_addr_d  = base_mod;
          state_d     = (num_sat == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (hs) begin
          // Covers both a stray last and a missing last on the final word.
          if (s_last_i != final_word) err_d = 1'b1;
          if (lane_full) begin
            wr_en_d                  = 1'b1;
            wr_addr_d                = cur_addr_q;
            wr_data_d                = pack_q;
            wr_data_d[K_CHANNELS-1]  = s_data_i;
            lane_cnt_d               = '0;
            entry_cnt_d              = entry_cnt_q + CNT_W'(1);
            cur_addr_d               = (cur_addr_q == LAST_ADDR) ? '0 : cur_addr_q + ADDR_W'(1);
            if (final_word) state_d  = DONE;
          end else begin
            pack_d[lane_cnt_q] = s_data_i;
            lane_cnt_d         = lane_cnt_q + LANE_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      state_q     <= IDLE;
      lane_cnt_q  <= '0;
      entry_cnt_q <= '0;
      num_q       <= '0;
      cur_addr_q  <= '0;
      wr_addr_q   <= '0;
      pack_q      <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_cnt_q  <= lane_cnt_d;
      entry_cnt_q <= entry_cnt_d;
      num_q       <= num_d;
      cur_addr_q  <= cur_addr_d;
      wr_addr_q   <= wr_addr_d;
      pack_q      <= pack_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      err_q       <= err_d;
    end
  end

  assign busy_o           = (state_q != IDLE);
  assign done_o           = (state_q == DONE);
  assign s_ready_o        = (state_q == LOAD);
  assign err_o            = err_q;
  assign loader_wr_en_o   = wr_en_q;
  assign loader_wr_addr_o = wr_addr_q;
  assign loader_wr_data_o = wr_data_q;

endmodule
